rvc_fetch_aligner: RTL and testbench

Parametrised fetch-side instruction aligner and RVC expander. Sits between the instruction-memory fetch port and the decoder. It accepts aligned fetch words of FETCH_W bits and buffers them as halfwords, so that 32-bit instructions can cross word boundaries. It emits one 32-bit instruction per handshake, with 16-bit instructions expanded to their RV64I/M equivalents, and it reports unsupported encodings as `inst_illegal` instead of stopping simulation.

---
 rtl/rvc_fetch_aligner.sv | 272 +++++++++++++++++++++++++++
 tb/tb_rvc_fetch_aligner.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rvc_fetch_aligner.sv
// Fetch-side halfword aligner with RV64C expander for the decoder front end.
// Define RVC_FETCH_RVC_EN to build the expander; otherwise 16-bit heads are flagged illegal.
module rvc_fetch_aligner #(
  parameter int          FETCH_W  = 64,
  parameter int          DEPTH    = 8,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [63:0]        flush_pc,
  input  logic               fetch_valid,
  output logic               fetch_ready,
  input  logic [63:0]        fetch_pc,
  input  logic [FETCH_W-1:0] fetch_data,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [63:0]        inst_pc,
  output logic [31:0]        inst,
  output logic               inst_is_rvc,
  output logic               inst_illegal
);

  localparam int HPF  = FETCH_W / 16;
  localparam int AW   = $clog2(DEPTH);
  localparam int OFFW = $clog2(FETCH_W / 8);
  localparam int HW   = OFFW - 1;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] HPF_C   = (AW+1)'(HPF);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);
  localparam logic [AW:0] TWO_C   = (AW+1)'(2);

  logic [15:0]   q [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [63:0]   pc_q;

  logic [HW-1:0] off;
  logic          push, pop;
  logic [AW:0]   push_n, pop_n;
  logic [15:0]   head_lo, head_hi;
  logic          head_is32;
  logic [31:0]   exp_inst;
  logic          exp_ill;
  logic          unused_bits;

  assign off         = fetch_pc[OFFW-1:1];
  assign unused_bits = ^{fetch_pc[63:OFFW], fetch_pc[0], flush_pc[0]};

  assign fetch_ready = ((DEPTH_C - count) >= HPF_C) && !flush;
  assign push        = fetch_valid && fetch_ready;
  assign push_n      = HPF_C - (AW+1)'(off);

  assign head_lo   = q[rd_ptr];
  assign head_hi   = q[rd_ptr + AW'(1)];
  assign head_is32 = (head_lo[1:0] == 2'b11);

  assign inst_valid = !flush && (head_is32 ? (count >= TWO_C) : (count >= ONE_C));
  assign pop        = inst_valid && inst_ready;
  assign pop_n      = head_is32 ? TWO_C : ONE_C;
  assign inst_pc    = pc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      pc_q   <= RESET_PC;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      pc_q   <= {flush_pc[63:1], 1'b0};
    end else begin
      if (push) wr_ptr <= wr_ptr + push_n[AW-1:0];
      if (pop) begin
        rd_ptr <= rd_ptr + pop_n[AW-1:0];
        pc_q   <= pc_q + (head_is32 ? 64'd4 : 64'd2);
      end
      count <= count + (push ? push_n : '0) - (pop ? pop_n : '0);
    end
  end

  // Halfwords below the fetch offset are skipped; the rest pack in from wr_ptr.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      for (int i = 0; i < HPF; i++) begin
        if (i >= int'(off)) q[wr_ptr + AW'(i) - AW'(off)] <= fetch_data[16*i +: 16];
      end
    end
  end

`ifdef RVC_FETCH_RVC_EN
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_REG32 = 7'b0111011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  // Offsets are passed without their always-zero bit 0.
  function automatic logic [31:0] enc_b(input logic [12:1] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], 5'd0, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:1] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd0, 7'b1101111};
  endfunction

  logic [15:0] c;
  logic [4:0]  rd, rs2, rdp, rs1p;
  logic [5:0]  imm6;
  logic [11:0] sx6;
  logic [9:0]  imm_4spn, imm_16sp;
  logic [6:0]  imm_lw;
  logic [7:0]  imm_ld, imm_lwsp, imm_swsp;
  logic [8:0]  imm_ldsp, imm_sdsp;
  logic [11:1] imm_j;
  logic [8:1]  imm_b;

  assign c        = head_lo;
  assign rd       = c[11:7];
  assign rs2      = c[6:2];
  assign rdp      = {2'b01, c[4:2]};
  assign rs1p     = {2'b01, c[9:7]};
  assign imm6     = {c[12], c[6:2]};
  assign sx6      = {{6{imm6[5]}}, imm6};
  assign imm_4spn = {c[10:7], c[12:11], c[5], c[6], 2'b00};
  assign imm_16sp = {c[12], c[4:3], c[5], c[2], c[6], 4'b0000};
  assign imm_lw   = {c[5], c[12:10], c[6], 2'b00};
  assign imm_ld   = {c[6:5], c[12:10], 3'b000};
  assign imm_lwsp = {c[3:2], c[12], c[6:4], 2'b00};
  assign imm_ldsp = {c[4:2], c[12], c[6:5], 3'b000};
  assign imm_swsp = {c[8:7], c[12:9], 2'b00};
  assign imm_sdsp = {c[9:7], c[12:10], 3'b000};
  assign imm_j    = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3]};
  assign imm_b    = {c[12], c[6:5], c[2], c[11:10], c[4:3]};

  always_comb begin
    exp_inst = 32'h0;
    exp_ill  = 1'b0;
    case (c[1:0])
      2'b00: begin
        case (c[15:13])
          3'b000: begin
            exp_ill  = (imm_4spn == 10'd0);
            exp_inst = enc_i({2'b00, imm_4spn}, 5'd2, 3'b000, rdp, OP_IMM);
          end
          3'b010:  exp_inst = enc_i({5'b0, imm_lw}, rs1p, 3'b010, rdp, OP_LOAD);
          3'b011:  exp_inst = enc_i({4'b0, imm_ld}, rs1p, 3'b011, rdp, OP_LOAD);
          3'b110:  exp_inst = enc_s({5'b0, imm_lw}, rdp, rs1p, 3'b010);
          3'b111:  exp_inst = enc_s({4'b0, imm_ld}, rdp, rs1p, 3'b011);
          default: exp_ill  = 1'b1;
        endcase
      end
      2'b01: begin
        case (c[15:13])
          3'b000: exp_inst = enc_i(sx6, rd, 3'b000, rd, OP_IMM);
          3'b001: begin
            exp_ill  = (rd == 5'd0);
            exp_inst = enc_i(sx6, rd, 3'b000, rd, OP_IMM32);
          end
          3'b010: exp_inst = enc_i(sx6, 5'd0, 3'b000, rd, OP_IMM);
          3'b011: begin
            if (rd == 5'd2) begin
              exp_ill  = (imm_16sp == 10'd0);
              exp_inst = enc_i({{2{imm_16sp[9]}}, imm_16sp}, 5'd2, 3'b000, 5'd2, OP_IMM);
            end else begin
              exp_ill  = (imm6 == 6'd0);
              exp_inst = {{14{imm6[5]}}, imm6, rd, OP_LUI};
            end
          end
          3'b100: begin
            case (c[11:10])
              2'b00: exp_inst = enc_i({6'b000000, imm6}, rs1p, 3'b101, rs1p, OP_IMM);
              2'b01: exp_inst = enc_i({6'b010000, imm6}, rs1p, 3'b101, rs1p, OP_IMM);
              2'b10: exp_inst = enc_i(sx6, rs1p, 3'b111, rs1p, OP_IMM);
              default: begin
                case ({c[12], c[6:5]})
                  3'b000:  exp_inst = enc_r(7'b0100000, rdp, rs1p, 3'b000, rs1p, OP_REG);
                  3'b001:  exp_inst = enc_r(7'b0000000, rdp, rs1p, 3'b100, rs1p, OP_REG);
                  3'b010:  exp_inst = enc_r(7'b0000000, rdp, rs1p, 3'b110, rs1p, OP_REG);
                  3'b011:  exp_inst = enc_r(7'b0000000, rdp, rs1p, 3'b111, rs1p, OP_REG);
                  3'b100:  exp_inst = enc_r(7'b0100000, rdp, rs1p, 3'b000, rs1p, OP_REG32);
                  3'b101:  exp_inst = enc_r(7'b0000000, rdp, rs1p, 3'b000, rs1p, OP_REG32);
                  default: exp_ill  = 1'b1;
                endcase
              end
            endcase
          end
          3'b101:  exp_inst = enc_j({{9{imm_j[11]}}, imm_j});
          default: exp_inst = enc_b({{4{imm_b[8]}}, imm_b}, rs1p, {2'b00, c[13]});
        endcase
      end
      2'b10: begin
        case (c[15:13])
          3'b000: exp_inst = enc_i({6'b000000, imm6}, rd, 3'b001, rd, OP_IMM);
          3'b010: begin
            exp_ill  = (rd == 5'd0);
            exp_inst = enc_i({4'b0, imm_lwsp}, 5'd2, 3'b010, rd, OP_LOAD);
          end
          3'b011: begin
            exp_ill  = (rd == 5'd0);
            exp_inst = enc_i({3'b0, imm_ldsp}, 5'd2, 3'b011, rd, OP_LOAD);
          end
          3'b100: begin
            if (!c[12]) begin
              if (rs2 == 5'd0) begin
                exp_ill  = (rd == 5'd0);
                exp_inst = enc_i(12'd0, rd, 3'b000, 5'd0, OP_JALR);
              end else begin
                exp_inst = enc_r(7'd0, rs2, 5'd0, 3'b000, rd, OP_REG);
              end
            end else if (rs2 == 5'd0) begin
              exp_inst = (rd == 5'd0) ? 32'h0010_0073 : enc_i(12'd0, rd, 3'b000, 5'd1, OP_JALR);
            end else begin
              exp_inst = enc_r(7'd0, rs2, rd, 3'b000, rd, OP_REG);
            end
          end
          3'b110:  exp_inst = enc_s({4'b0, imm_swsp}, rs2, 5'd2, 3'b010);
          3'b111:  exp_inst = enc_s({3'b0, imm_sdsp}, rs2, 5'd2, 3'b011);
          default: exp_ill  = 1'b1;
        endcase
      end
      default: exp_ill = 1'b0;
    endcase
  end
`else
  assign exp_inst = {16'h0000, head_lo};
  assign exp_ill  = 1'b1;
`endif

  // Outputs are zero whenever nothing is presented, so a partial 32-bit head never leaks.
  always_comb begin
    inst         = 32'h0;
    inst_is_rvc  = 1'b0;
    inst_illegal = 1'b0;
    if (inst_valid) begin
      if (head_is32) begin
        inst = {head_hi, head_lo};
      end else begin
        inst         = exp_ill ? {16'h0000, head_lo} : exp_inst;
        inst_illegal = exp_ill;
`ifdef RVC_FETCH_RVC_EN
        inst_is_rvc  = 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// Directed bench for rvc_fetch_aligner (FETCH_W=64, DEPTH=8); expectations follow RVC_FETCH_RVC_EN.
module tb_rvc_fetch_aligner;

`ifdef RVC_FETCH_RVC_EN
  localparam bit RVC = 1'b1;
`else
  localparam bit RVC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, flush, fetch_valid, fetch_ready, inst_valid, inst_ready;
  logic [63:0] flush_pc, fetch_pc, fetch_data, inst_pc;
  logic [31:0] inst;
  logic        inst_is_rvc, inst_illegal;

  int tests = 0;
  int failures = 0;

  rvc_fetch_aligner #(.FETCH_W(64), .DEPTH(8), .RESET_PC(64'h8000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .flush_pc(flush_pc),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
    .fetch_data(fetch_data), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_pc(inst_pc), .inst(inst), .inst_is_rvc(inst_is_rvc), .inst_illegal(inst_illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic fv, input logic [63:0] fpc,
                               input logic [63:0] fd, input logic ir);
    fetch_valid = fv;
    fetch_pc    = fpc;
    fetch_data  = fd;
    inst_ready  = ir;
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkInst(input string tag, input logic [63:0] pc, input logic [31:0] ins,
                           input logic rvc, input logic ill);
    checkOutput({tag, "_valid"}, 64'(inst_valid), 64'd1);
    checkOutput({tag, "_pc"}, inst_pc, pc);
    checkOutput({tag, "_inst"}, 64'(inst), 64'(ins));
    checkOutput({tag, "_rvc"}, 64'(inst_is_rvc), 64'(rvc));
    checkOutput({tag, "_ill"}, 64'(inst_illegal), 64'(ill));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; flush_pc = '0;
    fetch_valid = 1'b0; fetch_pc = '0; fetch_data = '0; inst_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #2;
    checkOutput("rst_valid", 64'(inst_valid), 64'd0);
    checkOutput("rst_fready", 64'(fetch_ready), 64'd1);
    checkOutput("rst_pc", inst_pc, 64'h8000_0000);
    checkOutput("rst_inst", 64'(inst), 64'd0);
    checkOutput("rst_rvc", 64'(inst_is_rvc), 64'd0);
    checkOutput("rst_ill", 64'(inst_illegal), 64'd0);

    // Word A: c.li x10,1 | c.addi4spn | c.nop | low half of addi x10,x0,1
    applyStimulus(1'b1, 64'h8000_0000, 64'h0513_0001_0040_4505, 1'b0);
    checkOutput("a_fready", 64'(fetch_ready), 64'd1);
    checkOutput("a_empty", 64'(inst_valid), 64'd0);
    tick();
    applyStimulus(1'b0, 64'h0, 64'h0, 1'b0);
    checkInst("cli", 64'h8000_0000, RVC ? 32'h0010_0513 : 32'h0000_4505, RVC, !RVC);
    tick();
    applyStimulus(1'b0, 64'h0, 64'h0, 1'b1);
    checkInst("cli_hold", 64'h8000_0000, RVC ? 32'h0010_0513 : 32'h0000_4505, RVC, !RVC);
    tick();
    checkInst("addi4spn", 64'h8000_0002, RVC ? 32'h0041_0413 : 32'h0000_0040, RVC, !RVC);
    tick();
    checkInst("nop", 64'h8000_0004, RVC ? 32'h0000_0013 : 32'h0000_0001, RVC, !RVC);
    tick();
    // Word B: upper half of the split instruction | 0x0000 | addi x0,x0,0
    applyStimulus(1'b1, 64'h8000_0008, 64'h0000_0013_0000_0010, 1'b1);
    checkOutput("split_wait", 64'(inst_valid), 64'd0);
    checkOutput("split_wait_pc", inst_pc, 64'h8000_0006);
    checkOutput("split_fready", 64'(fetch_ready), 64'd1);
    tick();
    applyStimulus(1'b0, 64'h0, 64'h0, 1'b1);
    checkInst("split", 64'h8000_0006, 32'h0010_0513, 1'b0, 1'b0);
    tick();
    checkOutput("zero_valid", 64'(inst_valid), 64'd1);
    checkOutput("zero_pc", inst_pc, 64'h8000_000A);
    checkOutput("zero_inst", 64'(inst), 64'd0);
    checkOutput("zero_ill", 64'(inst_illegal), 64'd1);
    tick();
    checkInst("after_zero", 64'h8000_000C, 32'h0000_0013, 1'b0, 1'b0);
    tick();
    checkOutput("drain_valid", 64'(inst_valid), 64'd0);
    checkOutput("drain_pc", inst_pc, 64'h8000_0010);

    // Flush with a buffered instruction, a concurrent fetch beat and a ready decoder
    applyStimulus(1'b1, 64'h8000_0010, 64'h0020_0113_0010_0093, 1'b0);
    tick();
    applyStimulus(1'b0, 64'h0, 64'h0, 1'b0);
    checkInst("pre_flush", 64'h8000_0010, 32'h0010_0093, 1'b0, 1'b0);
    flush = 1'b1;
    flush_pc = 64'h8000_0007;
    applyStimulus(1'b1, 64'h8000_0018, 64'h0040_0213_0030_0193, 1'b1);
    checkOutput("flush_valid", 64'(inst_valid), 64'd0);
    checkOutput("flush_fready", 64'(fetch_ready), 64'd0);
    tick();
    flush = 1'b0;
    applyStimulus(1'b0, 64'h0, 64'h0, 1'b1);
    checkOutput("post_flush_valid", 64'(inst_valid), 64'd0);
    checkOutput("post_flush_pc", inst_pc, 64'h8000_0006);
    applyStimulus(1'b1, 64'h8000_0006, 64'h0040_3333_2222_1111, 1'b1);
    tick();
    applyStimulus(1'b0, 64'h0, 64'h0, 1'b1);
    checkInst("redirect", 64'h8000_0006, RVC ? 32'h0041_0413 : 32'h0000_0040, RVC, !RVC);
    tick();
    checkOutput("redirect_drop", 64'(inst_valid), 64'd0);
    checkOutput("redirect_pc", inst_pc, 64'h8000_0008);

    // Fill the queue while the decoder stalls, then drain with overlapping push/pop
    applyStimulus(1'b1, 64'h8000_0008, 64'h0020_0113_0010_0093, 1'b0);
    tick();
    applyStimulus(1'b1, 64'h8000_0010, 64'h0040_0213_0030_0193, 1'b0);
    checkOutput("fill_fready", 64'(fetch_ready), 64'd1);
    tick();
    applyStimulus(1'b1, 64'h8000_0018, 64'h0060_0313_0050_0293, 1'b0);
    checkOutput("full_fready", 64'(fetch_ready), 64'd0);
    checkInst("full", 64'h8000_0008, 32'h0010_0093, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 64'h8000_0018, 64'h0060_0313_0050_0293, 1'b0);
    checkOutput("full_hold_fready", 64'(fetch_ready), 64'd0);
    checkInst("full_hold", 64'h8000_0008, 32'h0010_0093, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h8000_0018, 64'h0060_0313_0050_0293, 1'b1);
    tick();
    checkOutput("six_fready", 64'(fetch_ready), 64'd0);
    checkInst("drain1", 64'h8000_000C, 32'h0020_0113, 1'b0, 1'b0);
    tick();
    checkOutput("four_fready", 64'(fetch_ready), 64'd1);
    checkInst("drain2", 64'h8000_0010, 32'h0030_0193, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 64'h0, 64'h0, 1'b1);
    checkInst("drain3", 64'h8000_0014, 32'h0040_0213, 1'b0, 1'b0);
    tick();
    checkInst("drain4", 64'h8000_0018, 32'h0050_0293, 1'b0, 1'b0);
    tick();
    checkInst("drain5", 64'h8000_001C, 32'h0060_0313, 1'b0, 1'b0);
    tick();
    checkOutput("drained_valid", 64'(inst_valid), 64'd0);
    checkOutput("drained_pc", inst_pc, 64'h8000_0020);

    // Reset while a 32-bit instruction has only its lower half buffered
    applyStimulus(1'b1, 64'h8000_0020, 64'h0513_0001_0010_0093, 1'b1);
    tick();
    applyStimulus(1'b0, 64'h0, 64'h0, 1'b1);
    checkInst("pre_rst", 64'h8000_0020, 32'h0010_0093, 1'b0, 1'b0);
    tick();
    checkInst("pre_rst_16", 64'h8000_0024, RVC ? 32'h0000_0013 : 32'h0000_0001, RVC, !RVC);
    tick();
    checkOutput("partial_valid", 64'(inst_valid), 64'd0);
    checkOutput("partial_pc", inst_pc, 64'h8000_0026);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #2;
    checkOutput("midrst_valid", 64'(inst_valid), 64'd0);
    checkOutput("midrst_pc", inst_pc, 64'h8000_0000);
    checkOutput("midrst_fready", 64'(fetch_ready), 64'd1);
    applyStimulus(1'b1, 64'h8000_0000, 64'h0000_0013_0001_0001, 1'b0);
    tick();
    applyStimulus(1'b0, 64'h0, 64'h0, 1'b0);
    checkInst("after_rst", 64'h8000_0000, RVC ? 32'h0000_0013 : 32'h0000_0001, RVC, !RVC);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
